// File: rtl/m_mig_ui_model.sv
// rtl/m_mig_ui_model.sv - MIG 7-series DDR2 user-interface responder model backed by on-chip memory
//
// Ports:
//   w_clk, w_rst_n                  clock (stands in for ui_clk), async active-low reset
//   app_addr/app_cmd/app_en/app_rdy command channel (000 write, 001 read)
//   app_wdf_data/mask/wren/end/rdy  write-data channel, mask bit=1 keeps the byte
//   app_rd_data/valid/end           read return, one beat per burst, never back-pressured
//   init_calib_complete             high CALIB_CYCLES cycles after reset release
//   o_err                           sticky: bad command or write beat without app_wdf_end
module m_mig_ui_model #(
    parameter int ADDR_WIDTH   = 27,
    parameter int DATA_WIDTH   = 128,
    parameter int MASK_WIDTH   = 16,
    parameter int DEPTH_LOG2   = 10,
    parameter int CALIB_CYCLES = 64,
    parameter int RD_LATENCY   = 8,
    parameter int CMDQ_DEPTH   = 4,
    parameter int WDFQ_DEPTH   = 4,
    parameter int REF_INTERVAL = 0,
    parameter int REF_BUSY     = 4
) (
    input  logic                  w_clk,
    input  logic                  w_rst_n,
    input  logic [ADDR_WIDTH-1:0] app_addr,
    input  logic [2:0]            app_cmd,
    input  logic                  app_en,
    output logic                  app_rdy,
    input  logic [DATA_WIDTH-1:0] app_wdf_data,
    input  logic [MASK_WIDTH-1:0] app_wdf_mask,
    input  logic                  app_wdf_wren,
    input  logic                  app_wdf_end,
    output logic                  app_wdf_rdy,
    output logic [DATA_WIDTH-1:0] app_rd_data,
    output logic                  app_rd_data_valid,
    output logic                  app_rd_data_end,
    output logic                  init_calib_complete,
    output logic                  o_err
);

    localparam int CQ_AW = $clog2(CMDQ_DEPTH);
    localparam int WQ_AW = $clog2(WDFQ_DEPTH);
    localparam int CE_W  = 3 + DEPTH_LOG2;
    localparam int WE_W  = DATA_WIDTH + MASK_WIDTH;
    localparam int CAL_W = $clog2(CALIB_CYCLES + 1);

    // Only the word-index slice of the address is decoded; the rest aliases.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{app_addr[ADDR_WIDTH-1:DEPTH_LOG2+3], app_addr[2:0]};

    // ---------------- calibration ----------------
    logic             calib_q;
    logic [CAL_W-1:0] calib_cnt_q;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            calib_q     <= 1'b0;
            calib_cnt_q <= '0;
        end else if (!calib_q) begin
            if (calib_cnt_q == CAL_W'(CALIB_CYCLES - 1)) calib_q <= 1'b1;
            else calib_cnt_q <= calib_cnt_q + 1'b1;
        end
    end

    assign init_calib_complete = calib_q;

    // ---------------- refresh emulation ----------------
    logic ref_busy;

    generate
        if (REF_INTERVAL > 0) begin : g_ref
            logic [31:0] ref_cnt_q;
            logic [31:0] busy_cnt_q;

            always_ff @(posedge w_clk or negedge w_rst_n) begin
                if (!w_rst_n) begin
                    ref_cnt_q  <= '0;
                    busy_cnt_q <= '0;
                end else if (calib_q) begin
                    if (ref_cnt_q == 32'(REF_INTERVAL - 1)) begin
                        ref_cnt_q  <= '0;
                        busy_cnt_q <= 32'(REF_BUSY);
                    end else begin
                        ref_cnt_q <= ref_cnt_q + 32'd1;
                        if (busy_cnt_q != 32'd0) busy_cnt_q <= busy_cnt_q - 32'd1;
                    end
                end
            end

            assign ref_busy = (busy_cnt_q != 32'd0);
        end else begin : g_noref
            assign ref_busy = 1'b0;
        end
    endgenerate

    // ---------------- command and write-data queues ----------------
    logic [CE_W-1:0]  cq_mem_q [CMDQ_DEPTH];
    logic [WE_W-1:0]  wq_mem_q [WDFQ_DEPTH];
    logic [CQ_AW:0]   cq_wr_q, cq_rd_q;
    logic [WQ_AW:0]   wq_wr_q, wq_rd_q;
    logic             cq_empty, cq_full, wq_empty, wq_full;
    logic             cmd_push, wdf_push;

    assign cq_empty = (cq_wr_q == cq_rd_q);
    assign cq_full  = (cq_wr_q[CQ_AW] != cq_rd_q[CQ_AW]) &&
                      (cq_wr_q[CQ_AW-1:0] == cq_rd_q[CQ_AW-1:0]);
    assign wq_empty = (wq_wr_q == wq_rd_q);
    assign wq_full  = (wq_wr_q[WQ_AW] != wq_rd_q[WQ_AW]) &&
                      (wq_wr_q[WQ_AW-1:0] == wq_rd_q[WQ_AW-1:0]);

    assign app_rdy     = calib_q && !cq_full && !ref_busy;
    assign app_wdf_rdy = calib_q && !wq_full;
    assign cmd_push    = app_en && app_rdy;
    assign wdf_push    = app_wdf_wren && app_wdf_rdy;

    // ---------------- execute stage ----------------
    logic [CE_W-1:0]       cq_head;
    logic [WE_W-1:0]       wq_head;
    logic [2:0]            head_cmd;
    logic [DEPTH_LOG2-1:0] head_idx;
    logic                  is_wr, is_rd;
    logic                  cq_pop, mem_we, rd_go, bad_cmd;

    assign cq_head  = cq_mem_q[cq_rd_q[CQ_AW-1:0]];
    assign wq_head  = wq_mem_q[wq_rd_q[WQ_AW-1:0]];
    assign head_cmd = cq_head[CE_W-1:DEPTH_LOG2];
    assign head_idx = cq_head[DEPTH_LOG2-1:0];
    assign is_wr    = (head_cmd == 3'b000);
    assign is_rd    = (head_cmd == 3'b001);

    // A write without its data stalls the head, and with it every later command.
    assign mem_we  = !cq_empty && is_wr && !wq_empty;
    assign rd_go   = !cq_empty && is_rd;
    assign bad_cmd = !cq_empty && !is_wr && !is_rd;
    assign cq_pop  = mem_we || rd_go || bad_cmd;

    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];

    // Storage only: queue slots and backing memory are not cleared by reset.
    always_ff @(posedge w_clk) begin
        if (cmd_push) cq_mem_q[cq_wr_q[CQ_AW-1:0]] <= {app_cmd, app_addr[DEPTH_LOG2+2:3]};
        if (wdf_push) wq_mem_q[wq_wr_q[WQ_AW-1:0]] <= {app_wdf_data, app_wdf_mask};
        if (mem_we) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (!wq_head[b]) mem_q[head_idx][b*8 +: 8] <= wq_head[MASK_WIDTH + b*8 +: 8];
            end
        end
    end

    logic err_q, err_d;
    assign err_d = err_q || bad_cmd || (wdf_push && !app_wdf_end);

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            cq_wr_q <= '0;
            cq_rd_q <= '0;
            wq_wr_q <= '0;
            wq_rd_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (cmd_push) cq_wr_q <= cq_wr_q + 1'b1;
            if (cq_pop)   cq_rd_q <= cq_rd_q + 1'b1;
            if (wdf_push) wq_wr_q <= wq_wr_q + 1'b1;
            if (mem_we)   wq_rd_q <= wq_rd_q + 1'b1;
            err_q <= err_d;
        end
    end

    assign o_err = err_q;

    // ---------------- read return pipeline ----------------
    // Stage 0 captures the memory word at execute; RD_LATENCY further stages
    // give valid at accept edge + 1 + RD_LATENCY. Idle stages carry zero data.
    logic [RD_LATENCY:0]   rv_q;
    logic [DATA_WIDTH-1:0] rd_pipe_q [RD_LATENCY+1];

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            rv_q <= '0;
            for (int i = 0; i <= RD_LATENCY; i++) rd_pipe_q[i] <= '0;
        end else begin
            rv_q         <= {rv_q[RD_LATENCY-1:0], rd_go};
            rd_pipe_q[0] <= rd_go ? mem_q[head_idx] : '0;
            for (int i = 1; i <= RD_LATENCY; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
        end
    end

    assign app_rd_data       = rd_pipe_q[RD_LATENCY];
    assign app_rd_data_valid = rv_q[RD_LATENCY];
    assign app_rd_data_end   = rv_q[RD_LATENCY];

endmodule

// File: tb/tb_m_mig_ui_model.sv
// tb/tb_m_mig_ui_model.sv - randomized self-checking bench for m_mig_ui_model
module tb_m_mig_ui_model;

    localparam int AW  = 27;
    localparam int DW  = 128;
    localparam int MW  = 16;
    localparam int LAT = 8;
    localparam int NW  = 1024;

    logic          w_clk = 1'b0;
    logic          w_rst_n = 1'b0;
    logic [AW-1:0] app_addr = '0;
    logic [2:0]    app_cmd = '0;
    logic          app_en = 1'b0;
    logic          app_rdy;
    logic [DW-1:0] app_wdf_data = '0;
    logic [MW-1:0] app_wdf_mask = '0;
    logic          app_wdf_wren = 1'b0;
    logic          app_wdf_end = 1'b0;
    logic          app_wdf_rdy;
    logic [DW-1:0] app_rd_data;
    logic          app_rd_data_valid;
    logic          app_rd_data_end;
    logic          init_calib_complete;
    logic          o_err;

    m_mig_ui_model #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .DEPTH_LOG2(10),
        .CALIB_CYCLES(64), .RD_LATENCY(LAT), .CMDQ_DEPTH(4), .WDFQ_DEPTH(4),
        .REF_INTERVAL(100), .REF_BUSY(4)
    ) dut (
        .w_clk(w_clk), .w_rst_n(w_rst_n),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end), .init_calib_complete(init_calib_complete),
        .o_err(o_err)
    );

    always #5 w_clk = ~w_clk;

    int cyc = 0;
    always @(posedge w_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    `define CHK(tag, obs, exp) begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            errors++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic [DW-1:0] mem_m [NW];
    exp_t          exp_q [$];
    int            n_valid = 0;
    int            last_valid_cyc = 0;
    longint        sum_lo = 0;
    logic [DW-1:0] last_rd_data = '0;

    function automatic int widx(input logic [AW-1:0] a);
        return int'(a / 8) % NW;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] d,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < MW; b++) if (!m[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    always @(negedge w_clk) begin
        if (w_rst_n && app_rd_data_valid) begin
            exp_t e;
            n_valid++;
            last_valid_cyc = cyc;
            last_rd_data = app_rd_data;
            sum_lo += longint'(app_rd_data[31:0]);
            checks++;
            if (app_rd_data_end !== 1'b1) begin
                errors++;
                $error("FAIL rd_end observed=%0h expected=1", app_rd_data_end);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL rd_expected observed=0 expected=1");
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (app_rd_data !== e.data) begin
                    errors++;
                    $error("FAIL rd_data observed=%0h expected=%0h", app_rd_data, e.data);
                end
                checks++;
                if (cyc != e.due) begin
                    errors++;
                    $error("FAIL rd_latency observed=%0d expected=%0d", cyc, e.due);
                end
            end
        end
    end

    task automatic cmd_issue(input logic [2:0] c, input logic [AW-1:0] a, output int acc);
        logic ok;
        ok = 1'b0;
        acc = -1;
        app_cmd = c;
        app_addr = a;
        app_en = 1'b1;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge w_clk);
            ok = app_rdy;
            @(posedge w_clk);
            #1;
        end
        app_en = 1'b0;
        acc = cyc;
        `CHK("cmd_accept", ok, 1'b1)
    endtask

    task automatic wdf_issue(input logic [DW-1:0] d, input logic [MW-1:0] m);
        logic ok;
        ok = 1'b0;
        app_wdf_data = d;
        app_wdf_mask = m;
        app_wdf_end = 1'b1;
        app_wdf_wren = 1'b1;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge w_clk);
            ok = app_wdf_rdy;
            @(posedge w_clk);
            #1;
        end
        app_wdf_wren = 1'b0;
        `CHK("wdf_accept", ok, 1'b1)
    endtask

    task automatic wr_issue(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        logic c_ok, w_ok;
        app_cmd = 3'b000;
        app_addr = a;
        app_wdf_data = d;
        app_wdf_mask = m;
        app_wdf_end = 1'b1;
        app_en = 1'b1;
        app_wdf_wren = 1'b1;
        for (int k = 0; k < 300 && (app_en || app_wdf_wren); k++) begin
            @(negedge w_clk);
            c_ok = app_en && app_rdy;
            w_ok = app_wdf_wren && app_wdf_rdy;
            @(posedge w_clk);
            #1;
            if (c_ok) app_en = 1'b0;
            if (w_ok) app_wdf_wren = 1'b0;
        end
        `CHK("wr_accept", {app_en, app_wdf_wren}, 2'b00)
        app_en = 1'b0;
        app_wdf_wren = 1'b0;
        mem_m[widx(a)] = merge(mem_m[widx(a)], d, m);
    endtask

    task automatic rd_issue(input logic [AW-1:0] a);
        int acc;
        exp_t e;
        cmd_issue(3'b001, a, acc);
        e.data = mem_m[widx(a)];
        e.due = acc + 1 + LAT;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge w_clk);
        #1;
    endtask

    int            acc;
    int            nv;
    int            lows;
    int            k;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic [MW-1:0] rm;
    logic [DW-1:0] sd [5];

    initial begin
        for (int i = 0; i < NW; i++) mem_m[i] = '0;

        repeat (3) @(posedge w_clk);
        @(negedge w_clk);
        checks++;
        if (app_rdy !== 1'b0) begin errors++; $error("FAIL rst_app_rdy observed=%0h expected=0", app_rdy); end
        checks++;
        if (app_wdf_rdy !== 1'b0) begin errors++; $error("FAIL rst_wdf_rdy observed=%0h expected=0", app_wdf_rdy); end
        checks++;
        if (app_rd_data_valid !== 1'b0) begin errors++; $error("FAIL rst_valid observed=%0h expected=0", app_rd_data_valid); end
        checks++;
        if (app_rd_data_end !== 1'b0) begin errors++; $error("FAIL rst_end observed=%0h expected=0", app_rd_data_end); end
        checks++;
        if (app_rd_data !== {DW{1'b0}}) begin errors++; $error("FAIL rst_data observed=%0h expected=0", app_rd_data); end
        checks++;
        if (init_calib_complete !== 1'b0) begin errors++; $error("FAIL rst_calib observed=%0h expected=0", init_calib_complete); end
        checks++;
        if (o_err !== 1'b0) begin errors++; $error("FAIL rst_err observed=%0h expected=0", o_err); end

        @(posedge w_clk);
        #1 w_rst_n = 1'b1;
        repeat (63) @(posedge w_clk);
        @(negedge w_clk);
        `CHK("calib_63", init_calib_complete, 1'b0)
        `CHK("rdy_63", app_rdy, 1'b0)
        @(posedge w_clk);
        @(negedge w_clk);
        `CHK("calib_64", init_calib_complete, 1'b1)
        `CHK("rdy_64", app_rdy, 1'b1)
        `CHK("wdf_rdy_64", app_wdf_rdy, 1'b1)
        @(posedge w_clk);
        #1;

        wr_issue(27'd0, 128'h0000_0001_0000_0001_0000_0001_0000_0001, 16'h0000);
        nv = n_valid;
        rd_issue(27'd0);
        idle(15);
        `CHK("single_read_count", n_valid - nv, 1)
        `CHK("single_read_data", last_rd_data, 128'h0000_0001_0000_0001_0000_0001_0000_0001)

        wr_issue(27'd8, {DW{1'b0}}, 16'h0000);
        wr_issue(27'd8, {DW{1'b1}}, 16'hFFF0);
        rd_issue(27'd8);
        idle(15);
        `CHK("masked_data", last_rd_data, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF)

        for (int i = 0; i < 4; i++) cmd_issue(3'b000, AW'(i * 8), acc);
        @(negedge w_clk);
        `CHK("cmdq_full_rdy", app_rdy, 1'b0)
        @(posedge w_clk);
        #1;
        for (int i = 0; i < 5; i++) sd[i] = {$urandom, $urandom, $urandom, $urandom};
        fork
            cmd_issue(3'b000, 27'd32, acc);
            for (int i = 0; i < 5; i++) wdf_issue(sd[i], 16'h0000);
        join
        for (int i = 0; i < 5; i++) mem_m[i] = sd[i];
        idle(5);
        nv = n_valid;
        for (int i = 0; i < 5; i++) rd_issue(AW'(i * 8));
        idle(15);
        `CHK("stall_reads", n_valid - nv, 5)

        for (int i = 0; i < 300; i++) begin
            ra = AW'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                rd = {$urandom, $urandom, $urandom, $urandom};
                rm = MW'($urandom);
                wr_issue(ra, rd, rm);
            end else begin
                rd_issue(ra);
            end
        end
        idle(15);

        for (int i = 0; i < NW; i++) wr_issue(AW'(i * 8), {$urandom, $urandom, $urandom, 32'd1}, 16'h0000);
        idle(5);
        sum_lo = 0;
        nv = n_valid;
        for (int i = 0; i < NW; i++) rd_issue(AW'(i * 8));
        idle(15);
        `CHK("sweep_count", n_valid - nv, NW)
        `CHK("sweep_sum", sum_lo, longint'(NW))

        rd = {$urandom, $urandom, $urandom, $urandom};
        wr_issue(27'd8192, rd, 16'h0000);
        rd_issue(27'd0);
        idle(15);
        `CHK("alias_data", last_rd_data, rd)

        lows = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge w_clk);
            if (!app_rdy) lows++;
        end
        `CHK("refresh_lows", lows, 16)
        @(posedge w_clk);
        #1;
        nv = n_valid;
        for (int i = 0; i < 150; i++) rd_issue(AW'($urandom));
        idle(15);
        `CHK("refresh_burst", n_valid - nv, 150)

        `CHK("err_before", o_err, 1'b0)
        cmd_issue(3'b010, 27'd0, acc);
        idle(3);
        `CHK("err_set", o_err, 1'b1)
        idle(20);
        `CHK("err_sticky", o_err, 1'b1)

        nv = n_valid;
        rd_issue(27'd0);
        idle(3);
        w_rst_n = 1'b0;
        exp_q.delete();
        @(negedge w_clk);
        `CHK("mid_rst_valid", app_rd_data_valid, 1'b0)
        `CHK("mid_rst_calib", init_calib_complete, 1'b0)
        `CHK("mid_rst_err", o_err, 1'b0)
        `CHK("mid_rst_rdy", app_rdy, 1'b0)
        @(posedge w_clk);
        #1 w_rst_n = 1'b1;
        k = 0;
        while (!init_calib_complete && k < 200) begin
            @(posedge w_clk);
            #1;
            k++;
        end
        `CHK("recalib_cycles", k, 64)
        `CHK("no_read_after_rst", n_valid, nv)
        `CHK("err_cleared", o_err, 1'b0)
        rd_issue(27'd0);
        idle(15);
        `CHK("mem_kept_count", n_valid - nv, 1)
        `CHK("exp_drained", exp_q.size(), 0)

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL global_timeout observed=%0d expected=finish", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
